vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL expose the following parameters (name, default, meaning):
- CLK_DIV, 4: clk cycles per pixel; legal range 1..16.
- H_VISIBLE, 640: active pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_VISIBLE, 480: active lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: asserted level of h_sync.
- VS_POL, 0: asserted level of v_sync.
- CW, 10: width of the counters and pixel coordinates.
REQ-002 The block SHALL expose the following ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- reset, in, 1: asynchronous, active-high reset.
- en, in, 1: run request.
- pix_tick, out, 1: one-clk pixel strobe.
- h_sync, out, 1: horizontal sync.
- v_sync, out, 1: vertical sync.
- DE, out, 1: display enable.
- x_pixel, out, CW: horizontal count.
- y_pixel, out, CW: vertical count.
- line_start, out, 1: one-clk pulse at h=0.
- frame_start, out, 1: one-clk pulse at h=0, v=0.
- running, out, 1: FSM is in RUN.
REQ-003 Totals SHALL be H_TOTAL=H_VISIBLE+H_FP+H_SYNC+H_BP and V_TOTAL=V_VISIBLE+V_FP+V_SYNC+V_BP; both SHALL be less than 2^CW.

Function
REQ-004 The FSM SHALL have exactly two states: IDLE and RUN.
- IDLE to RUN: when en=1.
- RUN to IDLE: only on the pix_tick at which h=H_TOTAL-1 and v=V_TOTAL-1 while en=0 (graceful stop at a frame boundary).
REQ-005 In IDLE, the divider, h counter and v counter SHALL all be held at 0, and pix_tick SHALL be 0.
REQ-006 In RUN, the divider SHALL count 0..CLK_DIV-1 and wrap.
- pix_tick=1 for exactly the clk in which the divider equals CLK_DIV-1.
- When CLK_DIV=1, pix_tick SHALL be 1 on every RUN clk.
REQ-007 The h and v counters SHALL advance only on clk edges where pix_tick=1.
- h counts 0..H_TOTAL-1, then wraps to 0.
- v increments only when h wraps, and wraps to 0 after V_TOTAL-1.
REQ-008 Deasserting en mid-frame SHALL NOT truncate the frame; the full frame SHALL complete before the block returns to IDLE.
REQ-009 Reasserting en before the frame end SHALL cancel the pending stop, with no discontinuity in the counters.
REQ-010 All outputs except pix_tick and running SHALL be registered, decoded from the counter values, and lag the counters by exactly one clk.
REQ-011 h_sync SHALL equal HS_POL while H_VISIBLE+H_FP <= h < H_VISIBLE+H_FP+H_SYNC, and ~HS_POL otherwise.
REQ-012 v_sync SHALL equal VS_POL while V_VISIBLE+V_FP <= v < V_VISIBLE+V_FP+V_SYNC, and ~VS_POL otherwise.
REQ-013 DE SHALL be 1 iff h<H_VISIBLE and v<V_VISIBLE, and only while in RUN.
REQ-014 x_pixel and y_pixel SHALL carry the full h and v counts, including during blanking.
REQ-015 line_start SHALL pulse for one clk only, on the first output cycle showing h=0.
- This includes the first cycle after entering RUN.
REQ-016 frame_start SHALL pulse for one clk only, on the first output cycle showing h=0 and v=0.
- This includes the first cycle after entering RUN.
REQ-017 In IDLE, the registered outputs SHALL be: syncs deasserted (~POL), DE=0, x=0, y=0, and both pulses 0.

Reset
REQ-018 Reset SHALL act asynchronously and return the block to IDLE at any point, including mid-line and mid-sync.
REQ-019 During reset, every output SHALL take its IDLE value, and running SHALL be 0.
REQ-020 After reset releases with en=1, the block SHALL enter RUN on the first clk edge, and the first pix_tick SHALL occur CLK_DIV clks after that edge.

Verification
REQ-021 Defaults, en held at 1: the following SHALL hold.
- pix_tick period is 4 clk.
- h_sync is low for h=656..751, i.e. 96 pixels or 384 clk.
- v_sync is low for v=490..491.
- frame_start period is 1,680,000 clk.
REQ-022 Defaults: DE is high for exactly 640 pixels per line on v=0..479, and is 0 on v=480..524.
REQ-023 Drop en at v=100: the frame runs through v=524, h=799; running falls after the final pix_tick, and outputs go to IDLE values.
REQ-024 Drop en at v=100, then raise it at v=300: there is no stop, and frame_start recurs at the normal period.
REQ-025 Reset asserted at h=700, v=491: outputs are immediately syncs high, DE=0, x=y=0; on release with en=1, frame_start pulses.
REQ-026 Small configuration (CLK_DIV=1, H=4/1/1/2, V=3/1/1/1, HS_POL=1): the following SHALL hold.
- H_TOTAL is 8 and V_TOTAL is 6.
- h_sync is high only at h=5.
- The frame is 48 clk long.
- line_start pulses every 8 clk.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters with a graceful
// frame-boundary stop, and one-clock-lagged registered sync/DE/coordinate outputs.
module vga_timing_gen #(
  parameter int   CLK_DIV   = 4,
  parameter int   H_VISIBLE = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   CW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          pix_tick,
  output logic          h_sync,
  output logic          v_sync,
  output logic          DE,
  output logic [CW-1:0] x_pixel,
  output logic [CW-1:0] y_pixel,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    DIV_LAST = 4'(CLK_DIV - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [3:0]    div_q, div_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          tick_s, frame_end_s;

  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;

  function automatic logic in_window(input logic [CW-1:0] cnt, input int lo, input int hi);
    return (int'(cnt) >= lo) && (int'(cnt) < hi);
  endfunction

  assign tick_s      = (state_q == RUN) && (div_q == DIV_LAST);
  assign frame_end_s = tick_s && (h_q == H_LAST) && (v_q == V_LAST);

  // State and raster counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= 4'd0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // Next-state and counter advance; a stop request only takes effect at the frame end.
  always_comb begin
    state_d = state_q;
    div_d   = 4'd0;
    h_d     = '0;
    v_d     = '0;
    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
        else    state_d = IDLE;
      end
      RUN: begin
        div_d = tick_s ? 4'd0 : div_q + 4'd1;
        if (tick_s) begin
          h_d = (h_q == H_LAST) ? '0 : h_q + CNT_ONE;
          if (h_q == H_LAST) v_d = (v_q == V_LAST) ? '0 : v_q + CNT_ONE;
          else               v_d = v_q;
        end else begin
          h_d = h_q;
          v_d = v_q;
        end
        if (frame_end_s && !en) state_d = IDLE;
        else                    state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current counters; registered below, so outputs lag by one clk.
  always_comb begin
    hs_d = ~HS_POL;
    vs_d = ~VS_POL;
    de_d = 1'b0;
    x_d  = '0;
    y_d  = '0;
    ls_d = 1'b0;
    fs_d = 1'b0;
    if (state_q == RUN) begin
      hs_d = in_window(h_q, H_VISIBLE + H_FP, H_VISIBLE + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
      vs_d = in_window(v_q, V_VISIBLE + V_FP, V_VISIBLE + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
      de_d = in_window(h_q, 0, H_VISIBLE) && in_window(v_q, 0, V_VISIBLE);
      x_d  = h_q;
      y_d  = v_q;
      // div_q==0 marks the first clk of each pixel, so a pulse fires once per h=0.
      ls_d = (div_q == 4'd0) && (h_q == '0);
      fs_d = (div_q == 4'd0) && (h_q == '0) && (v_q == '0);
    end else begin
      hs_d = ~HS_POL;
      vs_d = ~VS_POL;
    end
  end

  // Registered output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      de_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      x_q  <= x_d;
      y_q  <= y_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end

  assign pix_tick    = tick_s;
  assign running     = (state_q == RUN);
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign DE          = de_q;
  assign x_pixel     = x_q;
  assign y_pixel     = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule
